// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: BOOT/RUN/HALT control of the program counter.
// Redirects seen during a stall are parked in a one-entry pending slot.
module pc_sequencer #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hazard_stall,
  input  logic            mem_stall,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_pc,
  input  logic            halt,
  input  logic            wake,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            redir_pending
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            pc_valid_reg;
  logic            pend_valid_reg;
  logic            pend_trap_reg;
  logic [XLEN-1:0] pend_pc_reg;

  logic            stall;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] raw_tgt [3];
  logic [XLEN-1:0] aln_tgt [3];

  assign stall  = hazard_stall | mem_stall;
  assign pc_inc = pc_reg + INC;

  // Index 0: trap, 1: flush, 2: predicted target.
  assign raw_tgt[0] = trap_pc;
  assign raw_tgt[1] = flush_pc;
  assign raw_tgt[2] = pred_pc;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_align
      assign aln_tgt[gi] = raw_tgt[gi] & ALIGN_MASK;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_VEC;
      pc_valid_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_trap_reg  <= 1'b0;
      pend_pc_reg    <= '0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg    <= RUN;
          pc_valid_reg <= 1'b1;
        end

        RUN: begin
          if (stall) begin
            // A parked trap outranks any later flush; a later trap always wins.
            if (trap) begin
              pend_valid_reg <= 1'b1;
              pend_trap_reg  <= 1'b1;
              pend_pc_reg    <= aln_tgt[0];
            end else if (flush && !(pend_valid_reg && pend_trap_reg)) begin
              pend_valid_reg <= 1'b1;
              pend_trap_reg  <= 1'b0;
              pend_pc_reg    <= aln_tgt[1];
            end
          end else begin
            pend_valid_reg <= 1'b0;
            pend_trap_reg  <= 1'b0;
            if (trap) begin
              pc_reg <= aln_tgt[0];
            end else if (flush) begin
              pc_reg <= aln_tgt[1];
            end else if (pend_valid_reg) begin
              pc_reg <= pend_pc_reg;
            end else if (halt && !wake) begin
              state_reg    <= HALT;
              pc_valid_reg <= 1'b0;
              pc_reg       <= pc_inc;
            end else if (pred_taken) begin
              pc_reg <= aln_tgt[2];
            end else begin
              pc_reg <= pc_inc;
            end
          end
        end

        HALT: begin
          if (trap) begin
            state_reg    <= RUN;
            pc_valid_reg <= 1'b1;
            pc_reg       <= aln_tgt[0];
          end else if (flush) begin
            state_reg    <= RUN;
            pc_valid_reg <= 1'b1;
            pc_reg       <= aln_tgt[1];
          end else if (wake) begin
            state_reg    <= RUN;
            pc_valid_reg <= 1'b1;
          end
        end

        default: begin
          state_reg    <= BOOT;
          pc_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc            = pc_reg;
  assign pc_valid      = pc_valid_reg;
  assign redir_pending = pend_valid_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector-table bench for pc_sequencer with a queue of expected outputs
// checked one edge after each stimulus is driven.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard_stall, mem_stall;
  logic        trap, flush, pred_taken, halt, wake;
  logic [31:0] trap_pc, flush_pc, pred_pc;
  logic [31:0] pc;
  logic        pc_valid, redir_pending;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hazard_stall (hazard_stall),
    .mem_stall    (mem_stall),
    .trap         (trap),
    .trap_pc      (trap_pc),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .pred_taken   (pred_taken),
    .pred_pc      (pred_pc),
    .halt         (halt),
    .wake         (wake),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .redir_pending(redir_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hs, ms;
    logic        tr;
    logic [31:0] tpc;
    logic        fl;
    logic [31:0] fpc;
    logic        pt;
    logic [31:0] ppc;
    logic        ha, wk;
    logic [31:0] e_pc;
    logic        e_valid, e_pend;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        valid, pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic hs, input logic ms,
                              input logic tr, input logic [31:0] tpc,
                              input logic fl, input logic [31:0] fpc,
                              input logic pt, input logic [31:0] ppc,
                              input logic ha, input logic wk,
                              input logic [31:0] e_pc, input logic e_valid,
                              input logic e_pend);
    vec_t v;
    v.hs = hs; v.ms = ms; v.tr = tr; v.tpc = tpc; v.fl = fl; v.fpc = fpc;
    v.pt = pt; v.ppc = ppc; v.ha = ha; v.wk = wk;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check32(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, req);
    end
  endtask

  task automatic check_state(input string tag, input int idx,
                             input logic [31:0] e_pc, input logic e_valid,
                             input logic e_pend);
    check32({tag, ".pc"}, idx, pc, e_pc);
    check32({tag, ".pc_valid"}, idx, {31'd0, pc_valid}, {31'd0, e_valid});
    check32({tag, ".redir_pending"}, idx, {31'd0, redir_pending}, {31'd0, e_pend});
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v, input int idx);
    exp_t e, got;
    hazard_stall = v.hs; mem_stall = v.ms;
    trap = v.tr; trap_pc = v.tpc;
    flush = v.fl; flush_pc = v.fpc;
    pred_taken = v.pt; pred_pc = v.ppc;
    halt = v.ha; wake = v.wk;
    e.idx = idx; e.pc = v.e_pc; e.valid = v.e_valid; e.pend = v.e_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_state("vec", got.idx, got.pc, got.valid, got.pend);
    $display("vec %0d: pc=%h valid=%0b pend=%0b", idx, pc, pc_valid, redir_pending);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    hazard_stall = 0; mem_stall = 0; trap = 0; flush = 0; pred_taken = 0;
    halt = 0; wake = 0; trap_pc = '0; flush_pc = '0; pred_pc = '0;

    //         hs ms tr tpc           fl fpc           pt ppc           ha wk  e_pc          v  p
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0000,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0004,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0008,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_000C,1,0));
    vecs.push_back(mk(0,0, 1,32'h500,      1,32'h300,      1,32'h400,      0,0, 32'h0000_0500,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        1,32'h300,      1,32'h400,      0,0, 32'h0000_0300,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        1,32'h403,      0,0, 32'h0000_0400,1,0));
    vecs.push_back(mk(0,0, 1,32'hFFFF_FFFE,0,32'h0,        0,32'h0,        0,0, 32'hFFFF_FFFC,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0000,1,0));
    vecs.push_back(mk(0,0, 1,32'h100,      0,32'h0,        0,32'h0,        0,0, 32'h0000_0100,1,0));
    // Stalled redirects: flush then trap overwrite, later flush must not win.
    vecs.push_back(mk(1,0, 0,32'h0,        1,32'h203,      0,32'h0,        0,0, 32'h0000_0100,1,1));
    vecs.push_back(mk(0,1, 1,32'h80,       0,32'h0,        0,32'h0,        0,0, 32'h0000_0100,1,1));
    vecs.push_back(mk(1,0, 0,32'h0,        1,32'h300,      1,32'h400,      0,0, 32'h0000_0100,1,1));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0080,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0084,1,0));
    vecs.push_back(mk(1,0, 0,32'h0,        1,32'h200,      0,32'h0,        0,0, 32'h0000_0084,1,1));
    vecs.push_back(mk(1,0, 0,32'h0,        1,32'h210,      0,32'h0,        0,0, 32'h0000_0084,1,1));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        1,32'h400,      0,0, 32'h0000_0210,1,0));
    vecs.push_back(mk(1,0, 0,32'h0,        1,32'h500,      0,32'h0,        0,0, 32'h0000_0210,1,1));
    vecs.push_back(mk(0,0, 0,32'h0,        1,32'h600,      0,32'h0,        0,0, 32'h0000_0600,1,0));
    vecs.push_back(mk(0,0, 1,32'h40,       0,32'h0,        0,32'h0,        0,0, 32'h0000_0040,1,0));
    // Halt / wake behaviour.
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        1,0, 32'h0000_0044,0,0));
    vecs.push_back(mk(1,0, 0,32'h0,        0,32'h0,        1,32'h400,      0,0, 32'h0000_0044,0,0));
    vecs.push_back(mk(0,1, 0,32'h0,        0,32'h0,        1,32'h800,      0,0, 32'h0000_0044,0,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        1,0, 32'h0000_0044,0,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,1, 32'h0000_0044,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0048,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        1,1, 32'h0000_004C,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        1,0, 32'h0000_0050,0,0));
    vecs.push_back(mk(0,0, 0,32'h0,        1,32'h700,      0,32'h0,        0,1, 32'h0000_0700,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        1,0, 32'h0000_0704,0,0));
    vecs.push_back(mk(0,0, 1,32'h900,      1,32'h700,      0,32'h0,        0,1, 32'h0000_0900,1,0));
    vecs.push_back(mk(1,0, 0,32'h0,        0,32'h0,        0,32'h0,        1,0, 32'h0000_0900,1,0));
    vecs.push_back(mk(0,0, 0,32'h0,        0,32'h0,        0,32'h0,        0,0, 32'h0000_0904,1,0));

    #3;
    check_state("reset", 0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state("boot", 0, 32'h0, 1'b0, 1'b0);
    $display("boot: pc=%h valid=%0b", pc, pc_valid);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset pulse in the middle of a stall with a trap parked.
    step(mk(1,0, 1,32'h80, 0,32'h0, 0,32'h0, 0,0, 32'h0000_0904,1,1), 100);
    trap = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_state("midrst", 0, 32'h0, 1'b0, 1'b0);
    $display("midrst: pc=%h valid=%0b pend=%0b", pc, pc_valid, redir_pending);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state("midrst_boot", 0, 32'h0, 1'b0, 1'b0);
    step(mk(1,0, 0,32'h0, 0,32'h0, 0,32'h0, 0,0, 32'h0000_0000,1,0), 101);
    step(mk(0,0, 0,32'h0, 0,32'h0, 0,32'h0, 0,0, 32'h0000_0004,1,0), 102);
    step(mk(0,0, 0,32'h0, 0,32'h0, 0,32'h0, 0,0, 32'h0000_0008,1,0), 103);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
